execute_mdu: RTL and testbench
==============================

# execute_mdu

Iterative RV32M multiply/divide unit instantiated in the execute stage beside the main ALU. It takes the forwarded operands of an M-extension instruction and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a bit-serial datapath. While it works it raises a stall request to the hazard unit, so the instruction stays in execute until the result is ready.

## Interface
- DATA_WIDTH, 32: operand/result width; must be even and ≥8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush_e  in  1  kills any in-flight or requested operation.
- start_e  in  1  a valid M instruction is in execute; held high while stalled.
- funct3_e  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_e, b_e  in  DATA_WIDTH  forwarded rs1/rs2 values (post forward mux); held stable while busy_e.
- result_e  out  DATA_WIDTH  registered result; valid when done_e=1; holds until the next accepted op.
- busy_e  out  1  stall request to the hazard unit.
- done_e  out  1  one-cycle pulse; result_e valid; pipeline may advance.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start_e & !flush_e, accept: latch funct3, operand magnitudes and result sign, clear the counter, go to RUN. If a special case applies, go directly to DONE with the final result loaded.
- Special cases, resolved at accept:
  - Divide by zero: DIV/DIVU quotient all ones; REM/REMU result = a_e.
  - Signed overflow (a_e=most negative, b_e=−1): DIV result = a_e; REM result = 0.
- RUN: one bit per cycle for DATA_WIDTH cycles.
  - Multiply: shift-add on magnitudes into a 2×DATA_WIDTH product.
  - Divide: restoring shift-subtract on magnitudes.
  - After the last iteration, apply sign correction (two's complement if the result sign is set) and load result_e. Go to DONE.
- Operand signedness: MULH signed×signed; MULHSU signed a × unsigned b; MULHU/DIVU/REMU unsigned.
- Result selection:
  - MUL returns the low DATA_WIDTH product bits; MULH* return the high bits.
  - Remainder sign follows the dividend.
  - Quotient sign is a XOR b (signed ops only).
- DONE: done_e=1 for exactly one cycle, then IDLE unconditionally. start_e is ignored in DONE, since it is the same instruction leaving execute.
- busy_e = (IDLE & start_e & !flush_e) | RUN. It is combinational from start_e, so the instruction is held in the cycle it arrives. busy_e is 0 in DONE.
- flush_e in any state: next state IDLE, no done_e, result_e unchanged, counter cleared. Flush wins over start in the same cycle.
- rst: state IDLE, result_e=0, done_e=0, counter=0. busy_e is forced 0 while rst=1.

## Timing
- Accept at cycle t → busy_e high t..t+DATA_WIDTH → done_e at t+DATA_WIDTH+1 (33-cycle stall for 32 bits).
- Special cases: busy_e high at t only, done_e at t+1.
- Back-to-back M ops: the second start_e seen in IDLE at t+DATA_WIDTH+2 is accepted. No bubble is inserted beyond the DONE cycle.
- rst or flush during RUN takes effect at the next edge. The next cycle is IDLE, and a new start_e is accepted then.
- result_e changes only on entry to DONE or on rst.

## Configuration
- MDU_FAST_MUL_EN defined: multiplies (funct3[2]=0) use a single-cycle combinational 2×DATA_WIDTH product computed at accept and go directly to DONE. This gives a multiply latency of 1 with busy_e high for one cycle. Divides stay iterative.
- Undefined: all ops use the iterative path with the latencies above.

## Test plan
- MUL a=7, b=−3 (0xFFFFFFFD), start at t → busy_e t..t+32, done_e at t+33, result_e=0xFFFFFFEB. With MDU_FAST_MUL_EN: done_e at t+1, same value.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU a=−1, b=2 → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA (−6). REM −20/3 → 0xFFFFFFFE (−2). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done_e at t+1. DIV 0x80000000/−1 → 0x80000000 and REM → 0, done_e at t+1.
- Start DIVU, assert flush_e at t+10 → no done_e, busy_e=0 at t+11, result_e unchanged. Start a new op at t+11 → done_e at t+44.
- Assert rst mid-RUN → busy_e=0, done_e=0, result_e=0 next cycle. Two consecutive MULs → done_e pulses at t+33 and t+67, busy_e low only at t+33.

Source files
------------

// File: rtl/execute_mdu.sv
// ---------------------------------------------------------------------------
// execute_mdu -- iterative RV32M multiply/divide unit for the execute stage.
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on the forwarded operands
// of an M-extension instruction. Multiplies use a bit-serial shift-add and
// divides use restoring shift-subtract, both on operand magnitudes. The sign
// is fixed up after the last iteration. While the unit works it requests a
// stall, so the instruction stays in execute until done_e pulses.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   flush_e   in   kills any in-flight or requested operation (beats start_e)
//   start_e   in   valid M instruction in execute; held high while stalled
//   funct3_e  in   op select (000 MUL .. 111 REMU)
//   a_e, b_e  in   rs1/rs2 values; held stable while busy_e
//   result_e  out  registered result; valid with done_e; held until next op
//   busy_e    out  stall request (combinational from start_e)
//   done_e    out  one-cycle completion pulse
//
// Optional feature macro: MDU_FAST_MUL_EN
//   Defined   -> multiplies finish at accept with a single-cycle
//                combinational product; divides stay iterative.
//   Undefined -> every op uses the iterative path (DATA_WIDTH+1 cycle stall).
// ---------------------------------------------------------------------------
module execute_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_e,
  input  logic                  start_e,
  input  logic [2:0]            funct3_e,
  input  logic [DATA_WIDTH-1:0] a_e,
  input  logic [DATA_WIDTH-1:0] b_e,
  output logic [DATA_WIDTH-1:0] result_e,
  output logic                  busy_e,
  output logic                  done_e
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]   ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0]   MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Conditional two's complement of a single-width value.
  function automatic logic [W-1:0] f_neg_w(input logic [W-1:0] x, input logic en);
    f_neg_w = en ? (~x + ONE_W) : x;
  endfunction

  // Conditional two's complement of a double-width product.
  function automatic logic [2*W-1:0] f_neg_2w(input logic [2*W-1:0] x, input logic en);
    f_neg_2w = en ? (~x + ONE_2W) : x;
  endfunction

  // MUL keeps the low half of the product, MULH/MULHSU/MULHU the high half.
  function automatic logic [W-1:0] f_mul_sel(input logic [2*W-1:0] p, input logic [1:0] op_lo);
    f_mul_sel = (op_lo == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Registers
  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_neg;      // final result must be negated
  logic [W-1:0]     r_opnd;     // multiplicand magnitude, or divisor magnitude
  logic [2*W-1:0]   r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_result;
  logic             r_done;

  // Accept-time decode
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic             w_neg;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_special;
  logic [W-1:0]     w_special_val;
  logic             w_fast_take;
  logic [W-1:0]     w_fast_val;

  // Iteration datapath
  logic [W:0]       w_mul_sum;
  logic [W:0]       w_div_shift;
  logic             w_div_ge;
  logic [W-1:0]     w_div_diff;
  logic [2*W-1:0]   w_acc_next;
  logic [W-1:0]     w_run_val;

  // Operand signedness per op: MULHSU treats only rs1 as signed.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3_e)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b0;
      end
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
  end

  assign w_a_neg = w_a_signed & a_e[W-1];
  assign w_b_neg = w_b_signed & b_e[W-1];
  assign w_a_mag = f_neg_w(a_e, w_a_neg);
  assign w_b_mag = f_neg_w(b_e, w_b_neg);

  // Result sign: remainder follows the dividend, everything else is a^b.
  always_comb begin
    w_neg = 1'b0;
    if (funct3_e[2] && funct3_e[1]) begin
      w_neg = w_a_neg;
    end else begin
      w_neg = w_a_neg ^ w_b_neg;
    end
  end

  // Divide special cases are resolved at accept and skip the iteration.
  always_comb begin
    w_div_zero    = funct3_e[2] && (b_e == ZERO_W);
    w_ovf         = funct3_e[2] && !funct3_e[0] && (a_e == MOST_NEG) && (b_e == ALL_ONES);
    w_special     = w_div_zero || w_ovf;
    w_special_val = ZERO_W;
    if (w_div_zero) begin
      w_special_val = funct3_e[1] ? a_e : ALL_ONES;
    end else if (w_ovf) begin
      w_special_val = funct3_e[1] ? ZERO_W : a_e;
    end else begin
      w_special_val = ZERO_W;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  assign w_fast_prod = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_b_mag};
  assign w_fast_take = ~funct3_e[2];
  assign w_fast_val  = f_mul_sel(f_neg_2w(w_fast_prod, w_neg), funct3_e[1:0]);
`else
  assign w_fast_take = 1'b0;
  assign w_fast_val  = ZERO_W;
`endif

  // One iteration of shift-add or restoring shift-subtract, plus the
  // sign-corrected result that is loaded after the final iteration.
  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set, then
    // shift the whole {partial, multiplier} pair right by one.
    w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and try the
    // subtract; the difference fits in W bits whenever it is kept.
    w_div_shift = r_acc[2*W-1:W-1];
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    w_div_diff  = w_div_shift[W-1:0] - r_opnd;
    w_acc_next  = {(2*W){1'b0}};
    w_run_val   = ZERO_W;
    if (r_op[2]) begin
      w_acc_next = {(w_div_ge ? w_div_diff : w_div_shift[W-1:0]), r_acc[W-2:0], w_div_ge};
      w_run_val  = f_neg_w(r_op[1] ? w_acc_next[2*W-1:W] : w_acc_next[W-1:0], r_neg);
    end else begin
      w_acc_next = {w_mul_sum, r_acc[W-1:1]};
      w_run_val  = f_mul_sel(f_neg_2w(w_acc_next, r_neg), r_op[1:0]);
    end
  end

  // Stall request: the arriving instruction is held in the very cycle it
  // shows up, so this must be combinational from start_e.
  assign busy_e = ~rst & (((r_state == S_IDLE) & start_e & ~flush_e) | (r_state == S_RUN));

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b000;
      r_neg    <= 1'b0;
      r_opnd   <= ZERO_W;
      r_acc    <= {(2*W){1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_result <= ZERO_W;
      r_done   <= 1'b0;
    end else if (flush_e) begin
      // Killed op: back to idle with no pulse; result_e keeps its value.
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_e) begin
            r_op   <= funct3_e;
            r_neg  <= w_neg;
            r_cnt  <= {CW{1'b0}};
            r_opnd <= funct3_e[2] ? w_b_mag : w_a_mag;
            r_acc  <= {{W{1'b0}}, (funct3_e[2] ? w_a_mag : w_b_mag)};
            if (w_special) begin
              r_result <= w_special_val;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_fast_take) begin
              r_result <= w_fast_val;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt == CNT_LAST) begin
            r_result <= w_run_val;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          // start_e here is the finished instruction leaving execute.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result_e = r_result;
  assign done_e   = r_done;

endmodule

// File: tb/tb_execute_mdu.sv
// ---------------------------------------------------------------------------
// tb_execute_mdu -- self-checking bench for execute_mdu (DATA_WIDTH = 32).
// Expected results and latencies are pushed to a scoreboard queue when an op
// is driven and popped when done_e is observed.
// ---------------------------------------------------------------------------
module tb_execute_mdu;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_e;
  logic         start_e;
  logic [2:0]   funct3_e;
  logic [W-1:0] a_e;
  logic [W-1:0] b_e;
  logic [W-1:0] result_e;
  logic         busy_e;
  logic         done_e;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_exp = 32'h0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;
  exp_t sb_q[$];

  logic [2:0]   arith_f [8] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [W-1:0] arith_a [8] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100};
  logic [W-1:0] arith_b [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2,
                                32'h3, 32'h3, 32'd7, 32'd7};
  logic [W-1:0] arith_r [8] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF,
                                32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2};

  logic [2:0]   spec_f [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd6, 3'd4};
  logic [W-1:0] spec_a [6] = '{32'd5, 32'd5, 32'd9, 32'd9, 32'h80000000, 32'h80000000};
  logic [W-1:0] spec_b [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [W-1:0] spec_r [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd9, 32'h0, 32'h80000000};

  always #5 clk = ~clk;

  execute_mdu #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush_e  (flush_e),
    .start_e  (start_e),
    .funct3_e (funct3_e),
    .a_e      (a_e),
    .b_e      (b_e),
    .result_e (result_e),
    .busy_e   (busy_e),
    .done_e   (done_e)
  );

  // Independent arithmetic reference for RV32M semantics.
  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'h0, b});
    logic [63:0] p;
    longint      q;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from accept to done_e (also the number of busy_e cycles).
  function automatic int exp_lat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    if (f[2]) begin
      if (b == 32'h0) return 1;
      if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return LAT;
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return LAT;
`endif
  endfunction

  // Drive an op (caller is at posedge+1) and push its expectation.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res);
    exp_t e;
    e.res = exp_res;
    e.lat = exp_lat(f, a, b);
    sb_q.push_back(e);
    funct3_e = f;
    a_e      = a;
    b_e      = b;
    start_e  = 1'b1;
  endtask

  // Count edges until done_e and busy_e-high cycles, including the current one.
  task automatic wait_done(output int n, output int nb, output bit seen);
    n    = 0;
    nb   = 0;
    seen = 1'b0;
    #1;
    if (busy_e) nb++;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (busy_e) nb++;
      if (done_e) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    flush_e  = 1'b0;
    start_e  = 1'b1;
    funct3_e = 3'd0;
    a_e      = 32'h5;
    b_e      = 32'h6;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_e !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_e); end
    checks++; if (done_e !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_e); end
    checks++; if (result_e !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_e); end
    rst     = 1'b0;
    start_e = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] r);
    int   n;
    int   nb;
    bit   seen;
    exp_t e;
    issue(f, a, b, r);
    wait_done(n, nb, seen);
    start_e = 1'b0;
    e = sb_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout f=%0d a=%h b=%h", tag, f, a, b); end
    checks++; if (result_e !== e.res) begin errors++; $display("FAIL %s_result f=%0d a=%h b=%h got %h want %h", tag, f, a, b, result_e, e.res); end
    checks++; if (n !== e.lat) begin errors++; $display("FAIL %s_latency f=%0d got %0d want %0d", tag, f, n, e.lat); end
    checks++; if (nb !== e.lat) begin errors++; $display("FAIL %s_busy_cycles f=%0d got %0d want %0d", tag, f, nb, e.lat); end
    last_exp = e.res;
    @(posedge clk);
    #1;
    checks++; if (done_e !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", tag, done_e); end
    checks++; if (result_e !== e.res) begin errors++; $display("FAIL %s_result_hold got %h want %h", tag, result_e, e.res); end
  endtask

  task automatic test_arith;
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      run_table_op("arith", arith_f[i], arith_a[i], arith_b[i], arith_r[i]);
    end
    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(7, 0));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(60, 1)) : $urandom;
      if (i == 3) b = 32'hFFFFFFFF;
      run_table_op("rand", f, a, b, model(f, a, b));
    end
  endtask

  task automatic test_special;
    for (int i = 0; i < 6; i++) begin
      run_table_op("special", spec_f[i], spec_a[i], spec_b[i], spec_r[i]);
    end
  endtask

  task automatic test_flush;
    bit   saw_done;
    int   n;
    int   nb;
    bit   seen;
    exp_t e;
    saw_done = 1'b0;
    funct3_e = 3'd5;
    a_e      = 32'd1000;
    b_e      = 32'd3;
    start_e  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done_e) saw_done = 1'b1;
    end
    flush_e = 1'b1;
    @(posedge clk);
    #1;
    if (done_e) saw_done = 1'b1;
    flush_e = 1'b0;
    start_e = 1'b0;
    #1;
    checks++; if (busy_e !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy_e); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done got %b want 0", saw_done); end
    checks++; if (result_e !== last_exp) begin errors++; $display("FAIL flush_result_kept got %h want %h", result_e, last_exp); end
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    wait_done(n, nb, seen);
    start_e = 1'b0;
    e = sb_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL flush_restart_timeout"); end
    checks++; if (n !== e.lat) begin errors++; $display("FAIL flush_restart_latency got %0d want %0d", n, e.lat); end
    checks++; if (result_e !== e.res) begin errors++; $display("FAIL flush_restart_result got %h want %h", result_e, e.res); end
    last_exp = e.res;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid;
    int   n;
    int   nb;
    bit   seen;
    exp_t e;
    funct3_e = 3'd0;
    a_e      = 32'h1234;
    b_e      = 32'h5678;
    start_e  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy_e !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy_e); end
    checks++; if (done_e !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done_e); end
    checks++; if (result_e !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", result_e); end
    rst = 1'b0;
    issue(3'd7, 32'd100, 32'd7, 32'd2);
    wait_done(n, nb, seen);
    start_e = 1'b0;
    e = sb_q.pop_front();
    checks++; if (!seen || n !== e.lat) begin errors++; $display("FAIL rst_restart_latency got %0d want %0d", n, e.lat); end
    checks++; if (result_e !== e.res) begin errors++; $display("FAIL rst_restart_result got %h want %h", result_e, e.res); end
    last_exp = e.res;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int   n;
    int   nb;
    bit   seen;
    exp_t e;
    issue(3'd0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    wait_done(n, nb, seen);
    e = sb_q.pop_front();
    checks++; if (!seen || n !== e.lat) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", n, e.lat); end
    checks++; if (result_e !== e.res) begin errors++; $display("FAIL b2b_first_result got %h want %h", result_e, e.res); end
    checks++; if (nb !== e.lat) begin errors++; $display("FAIL b2b_first_busy_cycles got %0d want %0d", nb, e.lat); end
    // Next M op is already waiting while the first sits in DONE.
    issue(3'd0, 32'd3, 32'd5, 32'd15);
    wait_done(n, nb, seen);
    start_e = 1'b0;
    e = sb_q.pop_front();
    checks++; if (!seen || n !== e.lat + 1) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", n, e.lat + 1); end
    checks++; if (nb !== e.lat) begin errors++; $display("FAIL b2b_second_busy_cycles got %0d want %0d", nb, e.lat); end
    checks++; if (result_e !== e.res) begin errors++; $display("FAIL b2b_second_result got %h want %h", result_e, e.res); end
    @(posedge clk);
    #1;
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
